// File: rtl/ahb_mem_bridge.sv
// AHB-Lite subordinate that turns each accepted transfer into one memory-controller
// request, stretching the data phase on WAIT and issuing the two-cycle ERROR response.
module ahb_mem_bridge #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int MaxWait   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic [AddrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic [DataWidth-1:0] hwdata,
  input  logic                 hready,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [DataWidth-1:0] hrdata,
  output logic                 req,
  output logic [AddrWidth-1:0] addr,
  output logic [DataWidth-1:0] wData,
  output logic                 write,
  input  logic [1:0]           resp,
  input  logic [DataWidth-1:0] rData
);

  localparam logic [2:0] BusSize = 3'($clog2(DataWidth / 8));
  localparam int         CntW    = $clog2(MaxWait + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CntW-1:0]        r_wait_cnt;
  logic [CntW-1:0]        w_wait_cnt_nxt;
  logic [AddrWidth-1:0]   r_addr;
  logic                   r_write;
  logic [DataWidth-1:0]   r_hrdata;
  logic                   w_accept;
  logic                   w_take;
  logic                   w_rd_done;
  state_t                 w_acc_state;
  logic                   w_unused;

  // Without byte strobes a write must cover the whole bus word.
  function automatic logic f_xfer_bad(input logic [AddrWidth-1:0] a,
                                      input logic [2:0]           sz,
                                      input logic                 wr);
    logic [AddrWidth-1:0] mask;
    mask = (AddrWidth'(1) << sz) - AddrWidth'(1);
    return ((a & mask) != '0) || (sz > BusSize) || (wr && (sz != BusSize));
  endfunction

  assign w_accept    = hsel & htrans[1] & hready;
  assign w_acc_state = f_xfer_bad(haddr, hsize, hwrite) ? S_ERR1 : S_ACCESS;
  assign w_unused    = htrans[0];

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = '0;
    w_take         = 1'b0;
    w_rd_done      = 1'b0;
    hreadyout      = 1'b1;
    hresp          = 1'b0;
    req            = 1'b0;
    case (r_state)
      S_IDLE, S_ERR2: begin
        hresp       = (r_state == S_ERR2);
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          w_take      = 1'b1;
          w_state_nxt = w_acc_state;
        end
      end
      S_ACCESS: begin
        req       = 1'b1;
        hreadyout = 1'b0;
        if (resp == 2'b00) begin
          hreadyout   = 1'b1;
          w_rd_done   = ~r_write;
          w_state_nxt = S_IDLE;
          if (w_accept) begin
            w_take      = 1'b1;
            w_state_nxt = w_acc_state;
          end
        end else if (resp == 2'b10) begin
          if (r_wait_cnt == CntW'(MaxWait - 1)) begin
            w_state_nxt = S_ERR1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = S_ERR1;
        end
      end
      S_ERR1: begin
        hresp       = 1'b1;
        hreadyout   = 1'b0;
        w_state_nxt = S_ERR2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_hrdata   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_take) begin
        r_addr  <= haddr;
        r_write <= hwrite;
      end
      if (w_rd_done) begin
        r_hrdata <= rData;
      end
    end
  end

  // Completing reads bypass the register so data returns in the same cycle.
  assign hrdata = w_rd_done ? rData : r_hrdata;
  assign addr   = r_addr;
  assign write  = r_write;
  assign wData  = hwdata;

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// Directed bench for ahb_mem_bridge: transaction-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_ahb_mem_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          hsel;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wData;
  logic          write;
  logic [1:0]    resp;
  logic [DW-1:0] rData;

  int n_pass  = 0;
  int n_total = 0;

  ahb_mem_bridge #(.DataWidth(DW), .AddrWidth(AW), .MaxWait(MW)) dut (
    .clk(clk), .reset(reset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .req(req),
    .addr(addr), .wData(wData), .write(write), .resp(resp), .rData(rData)
  );

  // Single subordinate on the bus: its own ready is the bus ready.
  assign hready = hreadyout;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit xfer_bad(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    int unsigned bytes;
    bytes = 32'd1 << sz;
    return ((a % bytes) != 0) || (bytes > DW / 8) || (wr && (bytes != DW / 8));
  endfunction

  // Reference model: a pending transfer, its WAIT count and the error-response phase.
  bit            m_busy;
  logic [31:0]   m_addr;
  bit            m_write;
  int            m_waits;
  int            m_err;
  logic [31:0]   m_hrdata;
  bit            e_req, e_rdy, e_hresp;
  logic [31:0]   e_hrdata;
  bit            fin, errnow;

  initial begin
    m_busy = 0; m_addr = 0; m_write = 0; m_waits = 0; m_err = 0; m_hrdata = 0;
    forever begin
      @(negedge clk);
      e_req    = m_busy;
      e_hresp  = (m_err != 0);
      e_rdy    = (m_err == 1) ? 1'b0 : (m_busy ? (resp == 2'b00) : 1'b1);
      e_hrdata = (m_busy && !m_write && resp == 2'b00) ? rData : m_hrdata;
      chk("cmp_req", req, e_req);
      chk("cmp_hreadyout", hreadyout, e_rdy);
      chk("cmp_hresp", hresp, e_hresp);
      chk("cmp_hrdata", hrdata, e_hrdata);
      if (e_req) begin
        chk("cmp_addr", addr, m_addr);
        chk("cmp_write", write, m_write);
        chk("cmp_wData", wData, hwdata);
      end
      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_addr = 0; m_write = 0; m_waits = 0; m_err = 0; m_hrdata = 0;
      end else if (m_err == 1) begin
        m_err = 2;
      end else begin
        fin = 1; errnow = 0;
        if (m_busy) begin
          if (resp == 2'b00) begin
            if (!m_write) m_hrdata = rData;
          end else if (resp == 2'b10) begin
            m_waits++;
            if (m_waits >= MW) errnow = 1;
            else fin = 0;
          end else begin
            errnow = 1;
          end
        end
        if (errnow) begin
          m_busy = 0; m_err = 1; m_waits = 0;
        end else if (fin) begin
          m_busy = 0; m_err = 0; m_waits = 0;
          if (hsel && htrans[1]) begin
            if (xfer_bad(haddr, hsize, hwrite)) m_err = 1;
            else begin
              m_busy = 1; m_addr = haddr; m_write = hwrite;
            end
          end
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
  endtask

  task automatic idle_in();
    hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
  endtask

  task automatic dp(input logic [1:0] r, input logic [31:0] wd, input logic [31:0] rd);
    resp = r; hwdata = wd; rData = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; idle_in(); dp(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    adv(); @(negedge clk);
    adv(); reset = 1'b0; @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_addr", addr, 0);
    chk("rst_write", write, 0);

    // Single read, OKAY on the first request cycle
    adv(); ap(32'h100, 1'b0, 3'd2); @(negedge clk);
    adv(); idle_in(); dp(2'b00, 32'h0, 32'hDEADBEEF); @(negedge clk);
    chk("rd_req", req, 1);
    chk("rd_addr", addr, 32'h100);
    chk("rd_write", write, 0);
    chk("rd_hreadyout", hreadyout, 1);
    chk("rd_hrdata", hrdata, 32'hDEADBEEF);
    adv(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    chk("rd_req_drop", req, 0);
    chk("rd_hrdata_hold", hrdata, 32'hDEADBEEF);

    // Write with three WAIT cycles
    adv(); ap(32'h200, 1'b1, 3'd2); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      adv(); idle_in(); dp(2'b10, 32'h12345678, 32'h0); @(negedge clk);
      chk("wr_wait_hreadyout", hreadyout, 0);
      chk("wr_wait_wData", wData, 32'h12345678);
      chk("wr_wait_addr", addr, 32'h200);
    end
    adv(); dp(2'b00, 32'h12345678, 32'h0); @(negedge clk);
    chk("wr_done_hreadyout", hreadyout, 1);
    chk("wr_done_hresp", hresp, 0);
    chk("wr_done_write", write, 1);
    adv(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);

    // Back-to-back reads with no bubble
    adv(); ap(32'h0, 1'b0, 3'd2); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      adv();
      if (i < 2) ap(32'(4 * (i + 1)), 1'b0, 3'd2);
      else idle_in();
      dp(2'b00, 32'h0, 32'hA0 + 32'(i)); @(negedge clk);
      chk("b2b_req", req, 1);
      chk("b2b_addr", addr, 32'(4 * i));
      chk("b2b_hrdata", hrdata, 32'hA0 + 32'(i));
    end
    adv(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    chk("b2b_end_req", req, 0);
    chk("b2b_end_hrdata", hrdata, 32'hA2);

    // BUSY while selected: zero-wait OKAY, no memory access
    adv(); hsel = 1'b1; htrans = 2'b01; haddr = 32'h300; @(negedge clk);
    adv(); idle_in(); @(negedge clk);
    chk("busy_req", req, 0);
    chk("busy_hresp", hresp, 0);

    // Misaligned read, then a transfer accepted during ERR2
    adv(); ap(32'h102, 1'b0, 3'd2); @(negedge clk);
    adv(); idle_in(); @(negedge clk);
    chk("mis_e1_req", req, 0);
    chk("mis_e1_hresp", hresp, 1);
    chk("mis_e1_hreadyout", hreadyout, 0);
    adv(); ap(32'h104, 1'b0, 3'd2); @(negedge clk);
    chk("mis_e2_hresp", hresp, 1);
    chk("mis_e2_hreadyout", hreadyout, 1);
    chk("mis_e2_req", req, 0);
    adv(); idle_in(); dp(2'b00, 32'h0, 32'h55AA55AA); @(negedge clk);
    chk("post_err_req", req, 1);
    chk("post_err_addr", addr, 32'h104);
    chk("post_err_hresp", hresp, 0);
    chk("post_err_hrdata", hrdata, 32'h55AA55AA);

    // Oversize read and narrow write both rejected; narrow aligned read accepted
    adv(); ap(32'h0, 1'b0, 3'd3); @(negedge clk);
    adv(); idle_in(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    chk("big_req", req, 0);
    chk("big_hresp", hresp, 1);
    adv(); @(negedge clk);
    adv(); ap(32'h2, 1'b1, 3'd1); @(negedge clk);
    adv(); idle_in(); @(negedge clk);
    chk("nwr_hresp", hresp, 1);
    chk("nwr_req", req, 0);
    adv(); @(negedge clk);
    adv(); ap(32'h3, 1'b0, 3'd0); @(negedge clk);
    adv(); idle_in(); dp(2'b00, 32'h0, 32'h77); @(negedge clk);
    chk("nrd_req", req, 1);
    chk("nrd_hresp", hresp, 0);

    // MaxWait-1 WAITs then OKAY: no error
    adv(); ap(32'h44, 1'b0, 3'd2); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    for (int i = 0; i < MW - 1; i++) begin
      adv(); idle_in(); dp(2'b10, 32'h0, 32'h0); @(negedge clk);
    end
    adv(); dp(2'b00, 32'h0, 32'h44444444); @(negedge clk);
    chk("w15_hreadyout", hreadyout, 1);
    chk("w15_hresp", hresp, 0);
    chk("w15_hrdata", hrdata, 32'h44444444);

    // WAIT timeout after MaxWait cycles
    adv(); ap(32'h40, 1'b0, 3'd2); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    for (int i = 0; i < MW; i++) begin
      adv(); idle_in(); dp(2'b10, 32'h0, 32'h0); @(negedge clk);
      chk("to_wait_req", req, 1);
    end
    adv(); @(negedge clk);
    chk("to_e1_req", req, 0);
    chk("to_e1_hresp", hresp, 1);
    chk("to_e1_hreadyout", hreadyout, 0);
    adv(); @(negedge clk);
    chk("to_e2_hresp", hresp, 1);
    chk("to_e2_hreadyout", hreadyout, 1);
    adv(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    chk("to_idle_hresp", hresp, 0);

    // Controller ERROR (01) on a read
    adv(); ap(32'h50, 1'b0, 3'd2); @(negedge clk);
    adv(); idle_in(); dp(2'b01, 32'h0, 32'h0); @(negedge clk);
    chk("er_req", req, 1);
    chk("er_hreadyout", hreadyout, 0);
    adv(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    chk("er_e1_hresp", hresp, 1);
    chk("er_e1_hreadyout", hreadyout, 0);
    adv(); @(negedge clk);
    chk("er_e2_hreadyout", hreadyout, 1);

    // Reserved response (11) on a write
    adv(); ap(32'h60, 1'b1, 3'd2); @(negedge clk);
    adv(); idle_in(); dp(2'b11, 32'hCAFEF00D, 32'h0); @(negedge clk);
    adv(); dp(2'b00, 32'h0, 32'h0); @(negedge clk);
    chk("r11_e1_hresp", hresp, 1);
    chk("r11_e1_req", req, 0);
    adv(); @(negedge clk);

    // Reset held two cycles in the middle of an access
    adv(); ap(32'h70, 1'b0, 3'd2); @(negedge clk);
    adv(); idle_in(); dp(2'b10, 32'h0, 32'h0); @(negedge clk);
    chk("mid_req", req, 1);
    adv(); reset = 1'b1; @(negedge clk);
    adv(); @(negedge clk);
    chk("mid_rst_req", req, 0);
    adv(); reset = 1'b0; @(negedge clk);
    chk("mid_rst_req2", req, 0);
    chk("mid_rst_hreadyout", hreadyout, 1);
    chk("mid_rst_hresp", hresp, 0);
    chk("mid_rst_hrdata", hrdata, 0);
    adv(); @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
